// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer blocks: default word width and input
// count, the frame-buffer state encoding, and a counter-width helper.
package dense_pkg;

  localparam int FIXED    = 32;
  localparam int NB_INPUT = 42;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_packer_if.sv
// Stream-in / frame-out bundle of the feature packer. The slave modport is the
// packer side, and the master modport is the producer/consumer side.
interface feature_packer_if #(
  parameter int FIXED    = dense_pkg::FIXED,
  parameter int NB_INPUT = dense_pkg::NB_INPUT
);

  logic [FIXED-1:0]          in_data;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic [NB_INPUT*FIXED-1:0] out_vec;
  logic                      out_valid;
  logic                      out_ready;
  logic                      frame_err;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_vec, out_valid, frame_err
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_vec, out_valid, frame_err
  );

endinterface

// File: rtl/feature_frame_buf.sv
// Storage for one feature frame. Each accepted word is written into slot wr_idx,
// and the whole frame is exposed in parallel.
module feature_frame_buf
  import dense_pkg::*;
#(
  parameter int FIXED    = dense_pkg::FIXED,
  parameter int NB_INPUT = dense_pkg::NB_INPUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [cnt_width(NB_INPUT)-1:0]    wr_idx,
  input  logic [FIXED-1:0]                  wr_data,
  output logic [NB_INPUT*FIXED-1:0]         frame
);

  // NOTE: this storage is reset even though it is wide, because a frame must read
  // as all-zero while reset is asserted and no stale frame may survive a reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame <= '0;
    end else if (wr_en) begin
      frame[wr_idx*FIXED +: FIXED] <= wr_data;
    end
  end

endmodule

// File: rtl/feature_packer.sv
// Serial-to-parallel packer: collects NB_INPUT words into one frame for the
// dense engine. Define FEATURE_PACKER_DBUF_EN to get ping-pong double buffering.
module feature_packer
  import dense_pkg::*;
#(
  parameter int FIXED    = dense_pkg::FIXED,
  parameter int NB_INPUT = dense_pkg::NB_INPUT
) (
  input  logic             clk,
  input  logic             rst,
  feature_packer_if.slave  bus
);

  localparam int CNT_W = cnt_width(NB_INPUT);

  logic [CNT_W-1:0] cnt_q;
  logic             ready_en_q;
  logic             frame_err_q;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             at_last;
  logic             complete;
  logic             early_last;
  logic             out_hs;

  assign accept     = bus.in_valid && in_ready;
  assign at_last    = (cnt_q == CNT_W'(NB_INPUT - 1));
  assign complete   = accept && at_last;
  assign early_last = accept && bus.in_last && !at_last;
  assign out_hs     = out_valid && bus.out_ready;

  // ready_en_q holds in_ready low while reset is asserted and releases it on the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      ready_en_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      frame_err_q <= (complete && !bus.in_last) || early_last;
      if (complete || early_last) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.frame_err = frame_err_q;

`ifdef FEATURE_PACKER_DBUF_EN

  // The write pointer always names the buffer that fills next. When that buffer is
  // still HOLD, both buffers are full.
  pack_state_e               buf_state_q [2];
  pack_state_e               buf_state_d [2];
  logic                      wr_sel_q, wr_sel_d;
  logic                      rd_sel_q, rd_sel_d;
  logic [NB_INPUT*FIXED-1:0] frames [2];

  for (genvar b = 0; b < 2; b++) begin : g_buf
    feature_frame_buf #(.FIXED(FIXED), .NB_INPUT(NB_INPUT)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && (wr_sel_q == 1'(b))),
      .wr_idx  (cnt_q),
      .wr_data (bus.in_data),
      .frame   (frames[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_state_q <= '{FILL, FILL};
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      buf_state_q <= buf_state_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    buf_state_d = buf_state_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    if (complete) begin
      buf_state_d[wr_sel_q] = HOLD;
      wr_sel_d              = !wr_sel_q;
    end
    if (out_hs) begin
      buf_state_d[rd_sel_q] = FILL;
      rd_sel_d              = !rd_sel_q;
    end
  end

  always_comb begin
    in_ready  = ready_en_q && (buf_state_q[wr_sel_q] == FILL);
    out_valid = (buf_state_q[rd_sel_q] == HOLD);
  end

  assign bus.out_vec = frames[rd_sel_q];

`else

  pack_state_e               state_q, state_d;
  logic [NB_INPUT*FIXED-1:0] frame;

  feature_frame_buf #(.FIXED(FIXED), .NB_INPUT(NB_INPUT)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_idx  (cnt_q),
    .wr_data (bus.in_data),
    .frame   (frame)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (complete) state_d = HOLD;
      HOLD:    if (out_hs)   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = ready_en_q && (state_q == FILL);
    out_valid = (state_q == HOLD);
  end

  assign bus.out_vec = frame;

`endif

endmodule

// File: doc/feature_packer.md
FEATURE_PACKER -- requirements
Module: feature_packer

Interface
REQ-001 SHALL have parameter FIXED, default 32: width of one fixed-point feature word.
REQ-002 SHALL have parameter NB_INPUT, default 42: number of words per frame (dense layer input count).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, FIXED: serial feature word.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_last, input, 1: marks the final word of a frame; qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1: packer can accept a word.
REQ-009 SHALL have port out_vec, output, NB_INPUT*FIXED: packed frame, word k at out_vec[k*FIXED +: FIXED], word 0 first received.
REQ-010 SHALL have port out_valid, output, 1: out_vec holds a complete frame.
REQ-011 SHALL have port out_ready, input, 1: dense engine accepts the frame.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on a framing error.

Function
REQ-013 SHALL accept a word only in cycles where in_valid and in_ready are both 1, writing it to slot cnt and incrementing cnt (0..NB_INPUT-1).
REQ-014 SHALL complete a frame when the word at cnt = NB_INPUT-1 is accepted; cnt SHALL wrap to 0 in the same cycle.
REQ-015 SHALL assert out_valid in the cycle after the completing word is accepted (latency 1).
REQ-016 SHALL hold out_vec and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL retire the presented frame on out_valid and out_ready both 1, deasserting out_valid the next cycle unless another complete frame is pending.
REQ-018 SHALL pulse frame_err when the completing word arrives with in_last=0; the frame SHALL still be completed and presented.
REQ-019 SHALL pulse frame_err when in_last=1 is accepted at cnt < NB_INPUT-1; the partial frame SHALL be discarded, cnt reset to 0, out_valid unaffected.
REQ-020 SHALL use single-buffer states FILL (in_ready=1) and HOLD (in_ready=0, out_valid=1): FILL->HOLD on frame completion, HOLD->FILL on output handshake.
REQ-021 SHALL make in_ready a pure function of registered state, never combinationally dependent on in_valid or out_ready.

Reset
REQ-022 SHALL, while rst=0, force cnt=0, state FILL, out_valid=0, frame_err=0, out_vec=0, in_ready=0.
REQ-023 SHALL drive in_ready=1 from the first clock edge after rst deasserts.
REQ-024 SHALL, on reset asserted mid-frame or mid-hold, discard all partial and held data without emitting frame_err.

Configuration
REQ-025 SHALL, with macro FEATURE_PACKER_DBUF_EN defined, implement two frame buffers: one filling while the other is presented; in_ready=0 only when both are full.
REQ-026 SHALL, with FEATURE_PACKER_DBUF_EN defined, present the filled buffer in the cycle after an output handshake when the completing word and the handshake occur in the same cycle, with no dropped or duplicated frame.
REQ-027 SHALL, without FEATURE_PACKER_DBUF_EN, implement the single-buffer FILL/HOLD behaviour of REQ-020.

Structure
REQ-028 SHALL take FIXED, NB_INPUT and the FILL/HOLD state encoding from shared package dense_pkg, used by all dense-layer blocks.
REQ-029 SHALL place frame storage plus slot write logic in one sub-module, feature_frame_buf, instantiated once or twice depending on FEATURE_PACKER_DBUF_EN.

Verification
REQ-030 SHALL cover a nominal frame: 42 words 0x00000001..0x0000002A with in_last on word 42 -> out_valid one cycle later, out_vec[31:0]=0x00000001, out_vec[1343:1312]=0x0000002A, frame_err=0.
REQ-031 SHALL cover backpressure: out_ready=0 for 10 cycles after a frame -> out_vec stable, in_ready=0 (single buffer), then out_ready=1 -> in_ready=1 the next cycle.
REQ-032 SHALL cover early last: in_last on word 5 -> one frame_err pulse, cnt=0, next 42 words form a clean frame.
REQ-033 SHALL cover missing last: 42 words with in_last=0 -> frame_err pulse and frame still presented.
REQ-034 SHALL cover mid-frame reset: rst=0 after 20 words -> out_valid=0, out_vec=0, frame_err=0; next 42 words produce a correct frame.
REQ-035 SHALL cover double-buffered streaming with FEATURE_PACKER_DBUF_EN: back-to-back frames with out_ready toggling 1/0 -> all frames delivered in order, none dropped.
